async_fifo_status: RTL and testbench

Parametrised dual-clock FIFO and successor to the basic async FIFO. It adds:
- depth derived from an address-width parameter, with a configurable synchroniser depth;
- registered Gray pointers;
- almost-full/almost-empty thresholds and per-domain fill levels;
- overflow/underflow pulses;
- an optional first-word-fall-through (FWFT) read mode.

It sits on every clock-domain crossing datapath, between a producer in wr_clk and a consumer in rd_clk.

---
 rtl/async_fifo_pkg.sv | 27 ++
 rtl/async_fifo_status_cdc_sync_vec.sv | 25 ++
 rtl/async_fifo_status.sv | 140 ++++++++++++++
 tb/tb_async_fifo_status.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock status FIFO: Gray-code conversion and depth derivation.
// Conversions work on a wide container; callers zero-extend and size-cast back to their pointer width.
package async_fifo_pkg;

  localparam int unsigned MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] ptr_t;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits stay zero, so the prefix XOR is exact for any narrower pointer.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = gray;
    for (int i = int'(MAX_PTR_W) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_status_cdc_sync_vec.sv
// Multi-flop synchroniser for a Gray-coded pointer bus; resets to zero in the destination domain.
module cdc_sync_vec #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the source bus through STAGES flops of the destination clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_status.sv
// Dual-clock FIFO with registered Gray pointers, per-domain fill levels, threshold flags,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module async_fifo_status
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 3,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AFULL_THRESH  = 6,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter int unsigned FWFT          = 0
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  // Full when the far pointer is exactly one lap behind: top two Gray bits differ.
  localparam logic [PW-1:0] FULL_MASK = PW'(2'b11) << (PW - 2);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_bin_q, wr_bin_d, wr_gray_q, rd_gray_sync_s, rd_bin_sync_s;
  logic          wr_accept_s, overflow_q;

  logic [PW-1:0]         rd_bin_q, rd_bin_d, rd_gray_q, wr_gray_sync_s, wr_bin_sync_s, fwft_adj_s;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d, underflow_q, underflow_d;
  logic                  mem_empty_s, mem_read_s;

  cdc_sync_vec #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_wr2rd (
    .clk_i  (rd_clk),
    .rst_n_i(rd_rst_n),
    .d_i    (wr_gray_q),
    .q_o    (wr_gray_sync_s)
  );

  cdc_sync_vec #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_rd2wr (
    .clk_i  (wr_clk),
    .rst_n_i(wr_rst_n),
    .d_i    (rd_gray_q),
    .q_o    (rd_gray_sync_s)
  );

  assign wr_accept_s   = wr_en && !full;
  assign wr_bin_d      = wr_accept_s ? wr_bin_q + PW'(1'b1) : wr_bin_q;
  assign rd_bin_sync_s = PW'(gray2bin(ptr_t'(rd_gray_sync_s)));
  assign full          = (wr_gray_q == (rd_gray_sync_s ^ FULL_MASK));
  assign wr_level      = wr_bin_q - rd_bin_sync_s;
  assign almost_full   = (wr_level >= PW'(AFULL_THRESH));
  assign overflow      = overflow_q;

  // Write pointer pair (Gray derived from next-state binary) and overflow pulse.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= PW'(bin2gray(ptr_t'(wr_bin_d)));
      overflow_q <= wr_en && full;
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge wr_clk) begin
    if (wr_accept_s) begin
      mem_q[wr_bin_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  assign mem_empty_s   = (rd_gray_q == wr_gray_sync_s);
  assign wr_bin_sync_s = PW'(gray2bin(ptr_t'(wr_gray_sync_s)));

  // Read-side next state; in FWFT mode the output register prefetches whenever it is vacant or being popped.
  always_comb begin
    mem_read_s  = 1'b0;
    rd_valid_d  = 1'b0;
    underflow_d = 1'b0;
    if (FWFT != 32'd0) begin
      mem_read_s  = !mem_empty_s && (!rd_valid_q || rd_en);
      rd_valid_d  = mem_read_s || (rd_valid_q && !rd_en);
      underflow_d = rd_en && !rd_valid_q;
    end else begin
      mem_read_s  = rd_en && !mem_empty_s;
      rd_valid_d  = mem_read_s;
      underflow_d = rd_en && mem_empty_s;
    end
    if (mem_read_s) begin
      rd_bin_d  = rd_bin_q + PW'(1'b1);
      rd_data_d = mem_q[rd_bin_q[ADDR_WIDTH-1:0]];
    end else begin
      rd_bin_d  = rd_bin_q;
      rd_data_d = rd_data_q;
    end
  end

  // Read pointer pair, output data register and read-side pulses.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= PW'(bin2gray(ptr_t'(rd_bin_d)));
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign fwft_adj_s   = (FWFT != 32'd0) ? PW'(rd_valid_q) : '0;
  assign rd_level     = wr_bin_sync_s - rd_bin_q + fwft_adj_s;
  assign almost_empty = (rd_level <= PW'(AEMPTY_THRESH));
  assign empty        = (FWFT != 32'd0) ? !rd_valid_q : mem_empty_s;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_async_fifo_status.sv
// Self-checking bench: instance 0 in standard read mode, instance 1 in FWFT mode, default geometry (depth 8).
module tb_async_fifo_status;

  localparam int PW = 4;
  localparam int SS = 2;

  logic wr_clk, rd_clk, wr_rst_n, rd_rst_n;
  int   wr_half = 5;
  int   rd_half = 5;

  logic [1:0]         wr_en, rd_en, full, almost_full, overflow, rd_valid, empty, almost_empty, underflow;
  logic [1:0][15:0]   wr_data, rd_data;
  logic [1:0][PW-1:0] wr_level, rd_level;

  logic [15:0] sbq [$];
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        wr;
    logic [15:0] data;
    logic        exp_full;
    logic        exp_afull;
    logic [3:0]  exp_level;
    logic        exp_ovf;
  } wvec_t;

  typedef struct {
    logic        rd;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_empty;
    logic        exp_udf;
    logic [3:0]  exp_level;
  } rvec_t;

  wvec_t wv [10];
  rvec_t rv [10];

  async_fifo_status #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .SYNC_STAGES(SS), .AFULL_THRESH(6),
                      .AEMPTY_THRESH(2), .FWFT(0)) u_std (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
    .wr_en(wr_en[0]), .wr_data(wr_data[0]), .full(full[0]), .almost_full(almost_full[0]),
    .wr_level(wr_level[0]), .overflow(overflow[0]), .rd_en(rd_en[0]), .rd_data(rd_data[0]),
    .rd_valid(rd_valid[0]), .empty(empty[0]), .almost_empty(almost_empty[0]),
    .rd_level(rd_level[0]), .underflow(underflow[0])
  );

  async_fifo_status #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .SYNC_STAGES(SS), .AFULL_THRESH(6),
                      .AEMPTY_THRESH(2), .FWFT(1)) u_fwft (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
    .wr_en(wr_en[1]), .wr_data(wr_data[1]), .full(full[1]), .almost_full(almost_full[1]),
    .wr_level(wr_level[1]), .overflow(overflow[1]), .rd_en(rd_en[1]), .rd_data(rd_data[1]),
    .rd_valid(rd_valid[1]), .empty(empty[1]), .almost_empty(almost_empty[1]),
    .rd_level(rd_level[1]), .underflow(underflow[1])
  );

  initial begin
    wr_clk = 1'b0;
    forever #(wr_half) wr_clk = ~wr_clk;
  end

  initial begin
    rd_clk = 1'b0;
    #3;
    forever #(rd_half) rd_clk = ~rd_clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset(input int m);
    check("rst_full", 32'(full[m]), 32'd0);
    check("rst_afull", 32'(almost_full[m]), 32'd0);
    check("rst_wr_level", 32'(wr_level[m]), 32'd0);
    check("rst_overflow", 32'(overflow[m]), 32'd0);
    check("rst_rd_data", 32'(rd_data[m]), 32'd0);
    check("rst_rd_valid", 32'(rd_valid[m]), 32'd0);
    check("rst_empty", 32'(empty[m]), 32'd1);
    check("rst_aempty", 32'(almost_empty[m]), 32'd1);
    check("rst_rd_level", 32'(rd_level[m]), 32'd0);
    check("rst_underflow", 32'(underflow[m]), 32'd0);
  endtask

  task automatic pop_check(input string name, input logic [15:0] act);
    if (sbq.size() == 0) check({name, "_extra"}, 32'd1, 32'd0);
    else check(name, 32'(act), 32'(sbq.pop_front()));
  endtask

  // Random-enable stream through instance m; enables are gated by the DUT flags.
  task automatic sweep(input int m, input int n_words, input int wr_pct, input int rd_pct);
    int   wr_cnt, rd_cnt, bound;
    logic ovf_seen, udf_seen;
    wr_cnt = 0; rd_cnt = 0; ovf_seen = 1'b0; udf_seen = 1'b0;
    bound = n_words * 6;
    sbq.delete();
    fork
      begin
        int cyc = 0;
        while (wr_cnt < n_words && cyc < bound) begin
          @(negedge wr_clk);
          cyc++;
          if (overflow[m]) ovf_seen = 1'b1;
          if (!full[m] && $urandom_range(99) < 32'(wr_pct)) begin
            wr_en[m] = 1'b1;
            wr_data[m] = 16'($urandom);
            sbq.push_back(wr_data[m]);
            wr_cnt++;
          end else begin
            wr_en[m] = 1'b0;
          end
        end
        @(negedge wr_clk);
        wr_en[m] = 1'b0;
      end
      begin
        int   cyc = 0;
        logic pend = 1'b0;
        while (rd_cnt < n_words && cyc < bound) begin
          @(negedge rd_clk);
          cyc++;
          if (underflow[m]) udf_seen = 1'b1;
          rd_en[m] = 1'b0;
          if (m == 0) begin
            if (pend) begin
              check("sweep_valid", 32'(rd_valid[m]), 32'd1);
              pop_check("sweep_data", rd_data[m]);
              rd_cnt++;
            end
            pend = !empty[m] && ($urandom_range(99) < 32'(rd_pct)) && (rd_cnt < n_words);
            rd_en[m] = pend;
          end else if (rd_valid[m] && $urandom_range(99) < 32'(rd_pct)) begin
            pop_check("sweep_fwft_data", rd_data[m]);
            rd_en[m] = 1'b1;
            rd_cnt++;
          end
        end
        @(negedge rd_clk);
        rd_en[m] = 1'b0;
      end
    join
    check("sweep_words_read", 32'(rd_cnt), 32'(n_words));
    check("sweep_sb_empty", 32'(sbq.size()), 32'd0);
    check("sweep_no_overflow", 32'(ovf_seen), 32'd0);
    check("sweep_no_underflow", 32'(udf_seen), 32'd0);
  endtask

  initial begin
    logic seen;
    wr_rst_n = 1'b0; rd_rst_n = 1'b0;
    wr_en = '0; rd_en = '0; wr_data = '0;
    repeat (3) @(posedge wr_clk);
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge wr_clk) wr_rst_n = 1'b1;
    @(negedge rd_clk) rd_rst_n = 1'b1;
    repeat (3) @(negedge wr_clk);

    for (int i = 0; i < 8; i++) begin
      wv[i] = '{1'b1, 16'(i + 1), (i == 7), (i + 1 >= 6), 4'(i + 1), 1'b0};
    end
    wv[8] = '{1'b1, 16'hDEAD, 1'b1, 1'b1, 4'd8, 1'b1};
    wv[9] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd8, 1'b0};
    for (int i = 0; i < 8; i++) begin
      rv[i] = '{1'b1, 1'b1, 16'(i + 1), (i == 7), 1'b0, 4'(7 - i)};
    end
    rv[8] = '{1'b1, 1'b0, 16'h0008, 1'b1, 1'b1, 4'd0};
    rv[9] = '{1'b0, 1'b0, 16'h0008, 1'b1, 1'b0, 4'd0};

    // Fill to full, then one write while full.
    for (int i = 0; i < 10; i++) begin
      @(negedge wr_clk);
      wr_en[0] = wv[i].wr;
      wr_data[0] = wv[i].data;
      @(posedge wr_clk);
      #1;
      check("fill_full", 32'(full[0]), 32'(wv[i].exp_full));
      check("fill_afull", 32'(almost_full[0]), 32'(wv[i].exp_afull));
      check("fill_wr_level", 32'(wr_level[0]), 32'(wv[i].exp_level));
      check("fill_overflow", 32'(overflow[0]), 32'(wv[i].exp_ovf));
    end
    wr_en[0] = 1'b0;

    repeat (SS + 2) @(posedge rd_clk);
    @(negedge rd_clk);
    check("drain_pre_level", 32'(rd_level[0]), 32'd8);
    check("drain_pre_empty", 32'(empty[0]), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge rd_clk);
      rd_en[0] = rv[i].rd;
      @(posedge rd_clk);
      #1;
      check("drain_valid", 32'(rd_valid[0]), 32'(rv[i].exp_valid));
      check("drain_data", 32'(rd_data[0]), 32'(rv[i].exp_data));
      check("drain_empty", 32'(empty[0]), 32'(rv[i].exp_empty));
      check("drain_underflow", 32'(underflow[0]), 32'(rv[i].exp_udf));
      check("drain_rd_level", 32'(rd_level[0]), 32'(rv[i].exp_level));
    end
    rd_en[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge wr_clk);
      seen = (wr_level[0] == 4'd0);
    end
    check("drain_wr_level_zero", 32'(seen), 32'd1);
    check("drain_full_clear", 32'(full[0]), 32'd0);

    // FWFT: head word must appear without any rd_en within SYNC_STAGES+1 read edges.
    check("fwft_pre_empty", 32'(empty[1]), 32'd1);
    @(negedge wr_clk);
    wr_en[1] = 1'b1;
    wr_data[1] = 16'h00A5;
    @(posedge wr_clk);
    #1;
    wr_en[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < SS + 1 && !seen; k++) begin
      @(posedge rd_clk);
      #1;
      seen = rd_valid[1];
    end
    check("fwft_valid_in_time", 32'(seen), 32'd1);
    check("fwft_data", 32'(rd_data[1]), 32'h00A5);
    check("fwft_empty_low", 32'(empty[1]), 32'd0);
    check("fwft_rd_level", 32'(rd_level[1]), 32'd1);
    repeat (2) @(posedge rd_clk);
    #1;
    check("fwft_hold_valid", 32'(rd_valid[1]), 32'd1);
    @(negedge rd_clk);
    rd_en[1] = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en[1] = 1'b0;
    check("fwft_pop_empty", 32'(empty[1]), 32'd1);
    check("fwft_pop_level", 32'(rd_level[1]), 32'd0);
    @(negedge rd_clk);
    rd_en[1] = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en[1] = 1'b0;
    check("fwft_underflow", 32'(underflow[1]), 32'd1);

    // Ratio sweeps: 3:1 on the standard instance, 1:3 on the FWFT instance.
    wr_half = 5; rd_half = 15;
    repeat (4) @(negedge rd_clk);
    sweep(0, 5000, 50, 90);
    wr_half = 15; rd_half = 5;
    repeat (4) @(negedge wr_clk);
    sweep(1, 5000, 90, 50);
    wr_half = 5; rd_half = 5;
    repeat (4) @(negedge wr_clk);

    // Wrap-around: repeated full fill/drain passes the pointers through 15 -> 0 many times.
    for (int c = 0; c < 20; c++) begin
      sbq.delete();
      for (int i = 0; i < 8; i++) begin
        @(negedge wr_clk);
        check("wrap_no_early_full", 32'(full[0]), 32'd0);
        wr_en[0] = 1'b1;
        wr_data[0] = 16'(c * 256 + i * 17 + 3);
        sbq.push_back(wr_data[0]);
      end
      @(negedge wr_clk);
      wr_en[0] = 1'b0;
      check("wrap_full", 32'(full[0]), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge rd_clk);
        seen = (rd_level[0] == 4'd8);
      end
      check("wrap_rd_level8", 32'(seen), 32'd1);
      for (int i = 0; i < 8; i++) begin
        @(negedge rd_clk);
        check("wrap_no_early_empty", 32'(empty[0]), 32'd0);
        rd_en[0] = 1'b1;
        @(posedge rd_clk);
        #1;
        rd_en[0] = 1'b0;
        pop_check("wrap_data", rd_data[0]);
      end
      check("wrap_empty", 32'(empty[0]), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge wr_clk);
        seen = (wr_level[0] == 4'd0) && !full[0];
      end
      check("wrap_wr_drained", 32'(seen), 32'd1);
    end

    // Both resets asserted while each FIFO holds 5 words.
    for (int i = 0; i < 5; i++) begin
      @(negedge wr_clk);
      wr_en = 2'b11;
      wr_data[0] = 16'(16'h0100 + i);
      wr_data[1] = 16'(16'h0200 + i);
    end
    @(negedge wr_clk);
    wr_en = 2'b00;
    repeat (6) @(negedge rd_clk);
    check("mid_pre_level_std", 32'(rd_level[0]), 32'd5);
    check("mid_pre_level_fwft", 32'(rd_level[1]), 32'd5);
    check("mid_pre_valid_fwft", 32'(rd_valid[1]), 32'd1);
    #2;
    wr_rst_n = 1'b0;
    rd_rst_n = 1'b0;
    #1;
    check_reset(0);
    check_reset(1);
    repeat (3) @(negedge wr_clk);
    wr_rst_n = 1'b1;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    repeat (4) @(negedge rd_clk);
    @(negedge wr_clk);
    for (int m = 0; m < 2; m++) begin
      check("post_rst_empty", 32'(empty[m]), 32'd1);
      check("post_rst_wr_level", 32'(wr_level[m]), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
